// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential restoring divider, one quotient bit per enabled clock. Sits beside
// the pipelined 4x4 multiplier and recovers a factor from a product:
// Q = A / B, R = A % B (unsigned).
//
// Parameters
//   DW  dividend / quotient width (must be >= VW)
//   VW  divisor / remainder width
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; priority over EN and start
//   EN     in   clock enable; low freezes every register and output
//   start  in   request, only honoured in IDLE with EN=1
//   A      in   dividend, captured on an accepted start
//   B      in   divisor, captured on an accepted start
//   Q      out  quotient, final while done=1, held until the next accept
//   R      out  remainder, final while done=1, held until the next accept
//   busy   out  high from the edge after accept through the DONE cycle
//   done   out  one enabled-cycle pulse, Q/R valid
//   dbz    out  divide-by-zero flag, valid with done
//
// Build option
//   SEQ_DIVIDER_DBZ_FASTPATH_EN  when defined, a zero divisor finishes after a
//   single RUN cycle with Q = all ones, R = A[VW-1:0] and dbz=1; busy is then
//   high for that one RUN cycle only. When undefined, a zero divisor runs the
//   full DW iterations (yielding the same Q/R) and dbz is tied low.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          EN,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;   // dividend shift register, MSB consumed first
  logic [DW-1:0] quo_q, quo_d;   // quotient, LSB receives each new bit
  logic [VW-1:0] dvs_q, dvs_d;   // captured divisor
  logic [VW-1:0] rem_q, rem_d;   // partial remainder after restore
  logic [CW-1:0] cnt_q, cnt_d;   // iterations left minus one
  logic [VW:0]   step;           // {next remainder, quotient bit}

`ifdef SEQ_DIVIDER_DBZ_FASTPATH_EN
  logic          dbz_q, dbz_d;
`endif

  // One restoring step. The trial remainder needs VW+1 bits because it can
  // reach 2*B-1 before the subtract; once restored it is below B again, so
  // only VW bits are carried to the next step. With B=0 the compare always
  // succeeds and the subtract is a no-op, which naturally gives Q = all ones
  // and leaves the last VW dividend bits in the remainder.
  function automatic logic [VW:0] div_step(input logic [VW-1:0] rem_in,
                                           input logic          msb,
                                           input logic [VW-1:0] dvs);
    logic [VW:0] trial;
    trial = {rem_in, msb};
    if (trial >= {1'b0, dvs}) begin
      return {VW'(trial - {1'b0, dvs}), 1'b1};
    end
    return {trial[VW-1:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
`ifdef SEQ_DIVIDER_DBZ_FASTPATH_EN
    dbz_d   = dbz_q;
`endif
    step    = div_step(rem_q, dvd_q[DW-1], dvs_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = A;
          dvs_d   = B;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(DW - 1);
`ifdef SEQ_DIVIDER_DBZ_FASTPATH_EN
          dbz_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        rem_d = step[VW:1];
        quo_d = {quo_q[DW-2:0], step[0]};
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`ifdef SEQ_DIVIDER_DBZ_FASTPATH_EN
        // Zero divisor: the dividend is still unshifted on the first RUN
        // edge, so the full-run result can be written in one go.
        if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_q[VW-1:0];
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---- register stage: reset wins over EN; EN low freezes everything ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
`ifdef SEQ_DIVIDER_DBZ_FASTPATH_EN
      dbz_q   <= 1'b0;
`endif
    end else if (EN) begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_DIVIDER_DBZ_FASTPATH_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign Q    = quo_q;
  assign R    = rem_q;
  assign done = (state_q == S_DONE);

`ifdef SEQ_DIVIDER_DBZ_FASTPATH_EN
  // The fast zero-divisor path keeps busy to its single RUN cycle.
  assign busy = (state_q == S_RUN) || ((state_q == S_DONE) && !dbz_q);
  assign dbz  = (state_q == S_DONE) && dbz_q;
`else
  assign busy = (state_q == S_RUN) || (state_q == S_DONE);
  assign dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Bench for seq_divider. A behavioural model tracks each division as "accepted
// at edge 0, finishes after a fixed number of enabled edges" and computes the
// result with plain / and %. A negedge compare process checks busy/done/dbz
// every cycle and Q/R whenever they are meaningful (done, or idle/held).
// Directed cases pin the model with hand-computed values; a full sweep and a
// randomized phase (random EN, ignored start pulses, zero divisors) follow.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

`ifdef SEQ_DIVIDER_DBZ_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          EN    = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] A     = '0;
  logic [VW-1:0] B     = '0;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          busy, done, dbz;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .EN    (EN),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_active = 1'b0;
  bit            m_fast   = 1'b0;
  bit            m_edbz   = 1'b0;
  int            m_k      = 0;
  logic [DW-1:0] m_eq = '0, m_hq = '0;
  logic [VW-1:0] m_er = '0, m_hr = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_hq     = '0;
      m_hr     = '0;
    end else if (EN) begin
      if (!m_active && start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_fast   = FAST && (B == 0);
        m_edbz   = m_fast;
        if (B == 0) begin
          m_eq = '1;
          m_er = VW'(A % 16);
        end else begin
          m_eq = DW'(A / B);
          m_er = VW'(A % B);
        end
      end else if (m_active) begin
        m_k++;
        if (m_k > (m_fast ? 1 : DW)) begin
          m_active = 1'b0;
          m_hq     = m_eq;
          m_hr     = m_er;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_done;
      bit e_busy;
      e_done = m_active && (m_k == (m_fast ? 1 : DW));
      e_busy = m_active && (!m_fast || m_k == 0);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("dbz",  32'(dbz),  32'(e_done && m_edbz));
      if (e_done) begin
        chk("q_done", 32'(Q), 32'(m_eq));
        chk("r_done", 32'(R), 32'(m_er));
      end else if (!m_active) begin
        chk("q_hold", 32'(Q), 32'(m_hq));
        chk("r_hold", 32'(R), 32'(m_hr));
      end
    end
  end

  // One division. lat counts negedges from the accept edge to the one where
  // done is seen (1 = right after edge 0); bcnt counts negedges with busy.
  task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input bit noise, input int pause_at, input bit rnd_en,
                         output logic [DW-1:0] q, output logic [VW-1:0] r,
                         output logic z, output int lat, output int bcnt);
    int n;
    bit acc;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    if (rnd_en) EN = ($urandom_range(0, 3) != 0);
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_active) begin
        acc = 1'b1;
        break;
      end
      if (rnd_en) EN = ($urandom_range(0, 3) != 0);
    end
    start = 1'b0;
    q = '0; r = '0; z = 1'b0; lat = 0; bcnt = 0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout: start not accepted within 50 cycles");
      EN = 1'b1;
      return;
    end
    n = 1;
    forever begin
      if (busy) bcnt++;
      if (done || n >= 200) break;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        A = DW'($urandom);
        B = VW'($urandom);
      end
      if (pause_at > 0 && n == pause_at) EN = 1'b0;
      if (pause_at > 0 && n == pause_at + 3) EN = 1'b1;
      if (rnd_en) EN = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    EN    = 1'b1;
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: done not seen within 200 cycles");
    end
    q = Q; r = R; z = dbz; lat = n;
  endtask

  initial begin
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
    int            lat, bc;
    int            ea, eb;

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_q",    32'(Q),    0);
    chk("rst_r",    32'(R),    0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dbz",  32'(dbz),  0);
    reset = 1'b0;

    // Directed, hand-computed
    run_div(8'd200, 4'd7, 1'b0, 0, 1'b0, q, r, z, lat, bc);
    chk("d200_7_q", 32'(q), 28);
    chk("d200_7_r", 32'(r), 4);
    chk("d200_7_lat", lat, 9);
    chk("d200_7_busy", bc, 9);

    run_div(8'd143, 4'd11, 1'b0, 0, 1'b0, q, r, z, lat, bc);
    chk("rt13x11_q", 32'(q), 13);
    chk("rt13x11_r", 32'(r), 0);

    run_div(8'd5, 4'd9, 1'b0, 0, 1'b0, q, r, z, lat, bc);
    chk("d5_9_q", 32'(q), 0);
    chk("d5_9_r", 32'(r), 5);

    run_div(8'd255, 4'd1, 1'b0, 0, 1'b0, q, r, z, lat, bc);
    chk("d255_1_q", 32'(q), 255);
    chk("d255_1_r", 32'(r), 0);

    run_div(8'd255, 4'd15, 1'b0, 0, 1'b0, q, r, z, lat, bc);
    chk("d255_15_q", 32'(q), 17);
    chk("d255_15_r", 32'(r), 0);

    run_div(8'hB3, 4'd0, 1'b0, 0, 1'b0, q, r, z, lat, bc);
    chk("dbz_q", 32'(q), 255);
    chk("dbz_r", 32'(r), 3);
    chk("dbz_flag", 32'(z), FAST ? 1 : 0);
    chk("dbz_lat", lat, FAST ? 2 : 9);
    chk("dbz_busy", bc, FAST ? 1 : 9);

    // start pulses with other operands during RUN are ignored
    run_div(8'd100, 4'd3, 1'b1, 0, 1'b0, q, r, z, lat, bc);
    chk("noise_q", 32'(q), 33);
    chk("noise_r", 32'(r), 1);
    chk("noise_lat", lat, 9);

    // EN low for 3 cycles mid-RUN delays done by exactly 3
    run_div(8'd250, 4'd13, 1'b0, 3, 1'b0, q, r, z, lat, bc);
    chk("pause_q", 32'(q), 19);
    chk("pause_r", 32'(r), 3);
    chk("pause_lat", lat, 12);

    // Reset after iteration 4
    @(negedge clk);
    A = 8'd77; B = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_q",    32'(Q),    0);
    chk("midrst_r",    32'(R),    0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_dbz",  32'(dbz),  0);
    reset = 1'b0;
    run_div(8'd77, 4'd5, 1'b0, 0, 1'b0, q, r, z, lat, bc);
    chk("after_rst_q", 32'(q), 15);
    chk("after_rst_r", 32'(r), 2);
    chk("after_rst_lat", lat, 9);

    // Full sweep: identity and remainder bound
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(DW'(a), VW'(b), 1'b0, 0, 1'b0, q, r, z, lat, bc);
        chk("sweep_id",  int'(q) * b + int'(r), a);
        chk("sweep_rlt", 32'(int'(r) < b), 1);
      end
    end

    // Randomized: random EN, random start noise, zero divisors included
    for (int i = 0; i < 300; i++) begin
      ea = int'($urandom_range(0, 255));
      eb = int'($urandom_range(0, 15));
      run_div(DW'(ea), VW'(eb), 1'($urandom_range(0, 1)), 0, 1'b1, q, r, z, lat, bc);
      chk("rand_q", 32'(q), (eb == 0) ? 255 : ea / eb);
      chk("rand_r", 32'(r), (eb == 0) ? ea % 16 : ea % eb);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
